// File: rtl/dff_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter_if
// Description : Requester-side bus of the shared-register arbiter. The lock
//               vector exists only when DFF_BANK_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_bank_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int CW   = 16
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] din;
`ifdef DFF_BANK_ARB_LOCK_EN
    logic [NREQ-1:0]   lock;
`endif
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      q;
    logic              q_valid;
    logic              busy;
    logic [CW-1:0]     wr_count;

`ifdef DFF_BANK_ARB_LOCK_EN
    modport master (output req, din, lock, input gnt, ack, q, q_valid, busy, wr_count);
    modport slave  (input req, din, lock, output gnt, ack, q, q_valid, busy, wr_count);
`else
    modport master (output req, din, input gnt, ack, q, q_valid, busy, wr_count);
    modport slave  (input req, din, output gnt, ack, q, q_valid, busy, wr_count);
`endif
endinterface
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter
// Description : Round-robin arbiter and write sequencer for a shared W-bit
//               register. Optional burst lock via DFF_BANK_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int CW   = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    dff_bank_arbiter_if.slave bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t          r_state,    w_state_n;
    logic [NREQ-1:0] r_gnt,      w_gnt_n;
    logic [NREQ-1:0] r_ack,      w_ack_n;
    logic [W-1:0]    r_q,        w_q_n;
    logic            r_q_valid,  w_q_valid_n;
    logic [CW-1:0]   r_wr_count, w_wr_count_n;
    logic [LW-1:0]   r_last,     w_last_n;
    logic [LW-1:0]   r_win,      w_win_n;
    logic            r_busy;

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [LW-1:0]   w_pick;
    logic            w_relock;

    // The current winner still sees ack in WRITE, so it is excluded there.
    always_comb begin
        w_elig  = bus.req;
        w_found = 1'b0;
        w_pick  = '0;
        if (r_state == WRITE) begin
            w_elig[r_win] = 1'b0;
        end
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && w_elig[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = LW'((int'(r_last) + k) % NREQ);
            end
        end
    end

`ifdef DFF_BANK_ARB_LOCK_EN
    assign w_relock = bus.lock[r_win] & bus.req[r_win];
`else
    assign w_relock = 1'b0;
`endif

    always_comb begin
        w_state_n    = r_state;
        w_gnt_n      = '0;
        w_ack_n      = '0;
        w_q_n        = r_q;
        w_q_valid_n  = r_q_valid;
        w_wr_count_n = r_wr_count;
        w_last_n     = r_last;
        w_win_n      = r_win;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n       = GRANT;
                    w_gnt_n[w_pick] = 1'b1;
                    w_last_n        = w_pick;
                    w_win_n         = w_pick;
                end
            end
            GRANT: begin
                // A winner that dropped req aborts; the pointer stays advanced.
                if (bus.req[r_win]) begin
                    w_state_n      = WRITE;
                    w_q_n          = bus.din[r_win*W +: W];
                    w_ack_n[r_win] = 1'b1;
                    w_q_valid_n    = 1'b1;
                    w_wr_count_n   = r_wr_count + 1'b1;
                end else begin
                    w_state_n = IDLE;
                end
            end
            WRITE: begin
                if (w_relock) begin
                    w_state_n      = GRANT;
                    w_gnt_n[r_win] = 1'b1;
                end else if (w_found) begin
                    w_state_n       = GRANT;
                    w_gnt_n[w_pick] = 1'b1;
                    w_last_n        = w_pick;
                    w_win_n         = w_pick;
                end else begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_wr_count <= '0;
            r_last     <= LW'(NREQ - 1);
            r_win      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_gnt      <= w_gnt_n;
            r_ack      <= w_ack_n;
            r_q        <= w_q_n;
            r_q_valid  <= w_q_valid_n;
            r_wr_count <= w_wr_count_n;
            r_last     <= w_last_n;
            r_win      <= w_win_n;
            r_busy     <= (w_state_n != IDLE);
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.ack      = r_ack;
    assign bus.q        = r_q;
    assign bus.q_valid  = r_q_valid;
    assign bus.busy     = r_busy;
    assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer for a shared W-bit D-flip-flop register (Q bank).
- Up to NREQ requesters compete to load the shared register; the block grants one at a time, captures the winner's data and acknowledges it.
- Sits between requester logic and the shared state register; it is the only writer of q.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, width of shared register and of each requester data slice.
- CW, 16, width of write counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request; held high until matching ack.
- din  input  NREQ*W  flattened data; requester i occupies bits [i*W +: W].
- gnt  output  NREQ  one-hot registered grant; all zero when none.
- ack  output  NREQ  one-hot single-cycle write acknowledge.
- q  output  W  shared register contents.
- q_valid  output  1  high once q has been written since reset.
- busy  output  1  high in GRANT or WRITE state.
- wr_count  output  CW  count of completed writes.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset (any state, including mid-GRANT/WRITE), applied at the next edge:
  - state=IDLE; gnt=0; ack=0; q=0; q_valid=0; wr_count=0.
  - last pointer=NREQ-1, so requester 0 has highest priority after reset.
- States: IDLE, GRANT, WRITE; all outputs registered.
- Arbitration (combinational):
  - Scan eligible req starting at (last+1) mod NREQ, ascending with wrap.
  - First set bit wins.
- IDLE:
  - If any req is set, go to GRANT and set gnt=onehot(winner), last=winner.
  - Otherwise stay in IDLE.
- GRANT (one cycle):
  - If req[winner] is still high: q <= din slice of winner; ack=onehot(winner); q_valid=1; wr_count+1 (wraps at 2^CW); gnt=0; go to WRITE.
  - If req[winner] has dropped (abort): no write, no ack, no count; gnt=0; go to IDLE; last is kept (already advanced).
- WRITE (one cycle, ack high):
  - Eligible set = req with the winner's bit masked, since the winner still sees ack this cycle.
  - If the eligible set is non-empty: go to GRANT with the new winner, gnt and last updated.
  - Otherwise go to IDLE.
- Latency: req rises at cycle 0 (IDLE) → gnt at edge 1 → q updated and ack at edge 2.
- Throughput: one write per 2 cycles under continuous contention.
- Requesters must drop req in the cycle after ack. If req is held, it is treated as a new request at the next arbitration.
- Fairness: a requester holding req waits at most NREQ-1 grants to other requesters.
- gnt and ack are never both non-zero; each is at most one-hot.
- q holds its value in every cycle without a GRANT-state write.
- Simultaneous reset and req: reset wins; the req is seen from IDLE on the following cycle.

Optional Feature:
- Macro: DFF_BANK_ARB_LOCK_EN.
- Defined:
  - Adds input port lock, NREQ wide.
  - In WRITE, if lock[winner] and req[winner] are both high, go straight to GRANT with the same winner; last is unchanged and other requesters are skipped.
  - This allows back-to-back burst writes, one every 2 cycles.
  - Lock is ignored in IDLE and GRANT.
- Undefined:
  - lock port does not exist.
  - The winner is always masked in WRITE, so a requester can never win two grants in a row while others are pending.

Test Plan:
- Reset then idle: reset high for 2 cycles, then low with req=0 → q=0, q_valid=0, gnt=0, busy=0, wr_count=0 held for 10 cycles.
- Single write: req=4'b0100, din slice2=8'hA5 → gnt=4'b0100 at edge 1; ack=4'b0100, q=8'hA5, q_valid=1, wr_count=1 at edge 2; busy=0 once back in IDLE.
- Round-robin: req=4'b1111 held, each requester drops on its ack → ack order 0,1,2,3, one ack every 2 cycles; q matches each requester's din in turn; wr_count=4.
- Abort: req=4'b0010, dropped during the GRANT cycle → no ack, q unchanged, wr_count unchanged, state returns to IDLE.
- Reset mid-operation: reset asserted during GRANT for requester 3 → next cycle gnt=0, ack=0, q=0, wr_count=0; after release, req=4'b1001 → requester 0 wins first.
- Lock (DFF_BANK_ARB_LOCK_EN): req=4'b0011, lock=4'b0001 for 3 writes → acks 0,0,0; lock drops → next ack is requester 1.
